multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Control sequencer for the multi-cycle variant of the RV32I core: one shared ALU and one unified instruction/data memory, reused across cycles.
- Moore FSM stepping each instruction through fetch, decode, execute, memory and writeback.
- Drives mux selects and write enables for the shared datapath; waits on a memory ready handshake.
- Produces aluOp for the existing ALU decoder and immSrc for the immediate extender.
- Counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
op  input  7  opcode from instruction register
zero  input  1  ALU zero flag
memReady  input  1  memory completes current access this cycle
memReq  output  1  memory access requested
adrSrc  output  1  memory address: 0=PC, 1=ALU result register
irWrite  output  1  load instruction register
pcWrite  output  1  PC enable = pcUpdate | (branch & zero)
regWrite  output  1  register file write enable
memWrite  output  1  data memory write enable
aluSrcA  output  2  00=PC, 01=oldPC, 10=rs1 data
aluSrcB  output  2  00=rs2 data, 01=immExt, 10=constant 4
resultSrc  output  2  00=ALUOut, 01=memory data, 10=ALU result
aluOp  output  2  00=add, 01=sub (branch), 10=funct-decoded
immSrc  output  2  00=I, 01=S, 10=B, 11=J; combinational from op
illegalOp  output  1  one-cycle pulse on unsupported opcode
instret  output  CNT_W  retired-instruction count

Behaviour:
- States (4-bit encoding): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Reset: state=FETCH; instret=0; while rst is high, regWrite, memWrite, pcWrite, irWrite and illegalOp are forced to 0.
- Outputs are Moore, decoded from the state only. Exceptions: memReady gating in FETCH and MEMWRITE; pcWrite, which depends on zero.
- Unlisted outputs are 0.
- FETCH: memReq=1, adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10. irWrite and pcUpdate are asserted only in the cycle memReady=1. Hold while memReady=0; go to DECODE when memReady=1.
- DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (branch target).
  - lw or sw -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - Any other opcode -> FETCH, with illegalOp=1 for this cycle. The instruction is not counted.
- MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: memReq=1, adrSrc=1. Hold until memReady=1, then -> MEMWB.
- MEMWB: resultSrc=01, regWrite=1 -> FETCH.
- MEMWRITE: memReq=1, adrSrc=1. memWrite=1 only in the cycle memReady=1 (single write). Then -> FETCH.
- EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10 -> ALUWB.
- EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10 -> ALUWB.
- ALUWB: resultSrc=00, regWrite=1 -> FETCH.
- BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1. pcWrite=zero -> FETCH.
- JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1 -> ALUWB.
- Latency with memReady tied to 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and I-type ALU: 4 cycles
  - beq: 3 cycles
  - jal: 4 cycles
  - Each memReady=0 cycle adds one cycle.
- Retirement: instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps modulo 2^CNT_W with no saturation.
- op is sampled only in DECODE and MEMADR. The IR is stable from FETCH completion onward.
- Async reset mid-instruction (e.g. in MEMREAD or MEMWRITE): state goes immediately to FETCH and enables drop in the same cycle. No partial write may be issued after rst rises.

Decomposition:
- Shared package holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - state encoding localparams
  - aluSrcA, aluSrcB, resultSrc and aluOp encodings
- One sub-module, instr_decoder: combinational op -> immSrc. Unknown op gives 00.

Test Plan:
- Reset with memReady=1, op=0000011 (lw): state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. regWrite=1 only in cycle 5; instret 0->1 on return to FETCH.
- sw with memReady low for 3 cycles in MEMWRITE: memWrite=0 for 3 cycles, then exactly one memWrite=1 cycle; total 7 cycles; instret +1.
- beq twice, once with zero=1 and once with zero=0: pcWrite=1 in BEQ only when zero=1; 3 cycles each.
- jal: JAL state has pcWrite=1 and aluSrcA=01, aluSrcB=10; ALUWB follows with regWrite=1; instret +1.
- op=1110011 (unsupported): illegalOp pulses one cycle in DECODE; FETCH follows; instret unchanged; no regWrite or memWrite.
- rst asserted mid-MEMWRITE while memReady=0, then released: memWrite never asserts; state=FETCH; instret=0.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared constants for the multi-cycle RV32I control sequencer: opcodes,
// state encoding and the datapath mux/ALU select encodings.
package multicycle_control_fsm_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECUTER = 4'd6;
    localparam state_t S_EXECUTEI = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BEQ      = 4'd9;
    localparam state_t S_JAL      = 4'd10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the sequencer (master) and the shared datapath (slave).
interface multicycle_control_fsm_if #(parameter int CNT_W = 32);
    import multicycle_control_fsm_pkg::*;

    // memReq stays high for the whole memory access; the access completes in
    // the cycle where memReady is sampled high while memReq is high.
    logic [6:0]       op;
    logic             zero;
    logic             memReady;
    logic             memReq;
    logic             adrSrc;
    logic             irWrite;
    logic             pcWrite;
    logic             regWrite;
    logic             memWrite;
    logic [1:0]       aluSrcA;
    logic [1:0]       aluSrcB;
    logic [1:0]       resultSrc;
    logic [1:0]       aluOp;
    logic [1:0]       immSrc;
    logic             illegalOp;
    logic [CNT_W-1:0] instret;
    state_t           state_dbg;

    modport master (
        input  op, zero, memReady,
        output memReq, adrSrc, irWrite, pcWrite, regWrite, memWrite,
               aluSrcA, aluSrcB, resultSrc, aluOp, immSrc, illegalOp,
               instret, state_dbg
    );

    modport slave (
        output op, zero, memReady,
        input  memReq, adrSrc, irWrite, pcWrite, regWrite, memWrite,
               aluSrcA, aluSrcB, resultSrc, aluOp, immSrc, illegalOp,
               instret, state_dbg
    );

endinterface

// File: rtl/multicycle_control_fsm_instr_decoder.sv
// Opcode to immediate-format select for the immediate extender.
module multicycle_control_fsm_instr_decoder
    import multicycle_control_fsm_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for the multi-cycle RV32I core: steps each
// instruction through fetch/decode/execute/memory/writeback and counts retirements.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_control_fsm_if.master  bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;

    logic       mem_req, adr_src, ir_write, pc_update, branch;
    logic       reg_write, mem_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic [1:0] imm_src;

    multicycle_control_fsm_instr_decoder u_instr_decoder (
        .op      (bus.op),
        .imm_src (imm_src)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    if (bus.memReady) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.memReady) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWRITE: begin
                if (bus.memReady) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECUTER, S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB, S_BEQ: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_comb begin
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        illegal    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = bus.memReady;
                pc_update  = bus.memReady;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                illegal   = !op_supported(bus.op);
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = bus.memReady;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated by rst directly so nothing fires between rst rising and the next edge.
    assign bus.memReq    = mem_req;
    assign bus.adrSrc    = adr_src;
    assign bus.irWrite   = ir_write & ~rst;
    assign bus.pcWrite   = (pc_update | (branch & bus.zero)) & ~rst;
    assign bus.regWrite  = reg_write & ~rst;
    assign bus.memWrite  = mem_write & ~rst;
    assign bus.illegalOp = illegal & ~rst;
    assign bus.aluSrcA   = alu_src_a;
    assign bus.aluSrcB   = alu_src_b;
    assign bus.resultSrc = result_src;
    assign bus.aluOp     = alu_op;
    assign bus.immSrc    = imm_src;
    assign bus.instret   = instret_q;
    assign bus.state_dbg = state_q;

endmodule
